frequency_correction: RTL
=========================

Name: frequency_correction

Overview:
Sits directly downstream of the packet synchronization stage. It consumes that stage's stream: {Q,I} samples, a per-sample frequency-offset estimate on the user field, and a last flag marking the end of the short preamble. When it sees that last flag it latches the offset. It then de-rotates the next LENGTH samples with a phase accumulator and a pipelined CORDIC, and emits the corrected samples with m_last on the final one. Samples outside a tracking window are consumed and discarded.

Parameters:
WIDTH, 16, I/Q component width in bits.
PHASE_WIDTH, 32, phase and frequency word width; 2^PHASE_WIDTH spans 2π, signed, so 2^(PHASE_WIDTH-1) = π.
STAGES, 16, number of CORDIC micro-rotation stages.
LENGTH, 240, samples emitted per tracking window (long training plus SIGNAL field).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  2*WIDTH  {Q,I} signed sample
s_user  in  PHASE_WIDTH  signed per-sample frequency estimate (phase units per sample)
s_last  in  1  end of short preamble; the beat carrying it is the first sample of the window
m_valid  out  1  corrected sample valid
m_ready  in  1  downstream ready
m_data  out  2*WIDTH  corrected {Q,I}
m_last  out  1  high on the LENGTH-th output of a window
tracking  out  1  high while in TRACK

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: m_valid=0, m_last=0, m_data=0, tracking=0, state=SEARCH, phase accumulator=0, frequency register=0, counter=0, all pipeline valids cleared.
- Handshakes: beat transfers when valid&&ready. Pipeline enable en = !m_valid || m_ready. s_ready = en in both states, so the whole pipeline stalls together. m_data and m_last hold stable while m_valid && !m_ready. No combinational path from s_valid to m_valid.
- State SEARCH:
  - Accepted beats are dropped and nothing enters the pipeline.
  - An accepted beat with s_last=1 does four things: latches freq <= s_user; sets acc <= 0; pushes the beat into the pipeline with angle 0 and counter=1; moves to TRACK.
- State TRACK:
  - Each accepted beat enters the pipeline with angle = -(acc + freq), mod 2^PHASE_WIDTH; then acc <= acc + freq and counter increments.
  - Equivalently, sample n of the window (n=0 is the s_last beat) is rotated by -n*freq.
  - The beat that brings counter to LENGTH is tagged last, and the state returns to SEARCH at the same time.
  - s_last seen during TRACK is ignored and the beat is treated as an ordinary sample.
- Wrap-around: acc and the angle wrap modulo 2^PHASE_WIDTH with no saturation.
- CORDIC rotation:
  - Stage 0 is quadrant pre-rotation. If |angle| > π/2, rotate by ±π/2 via swap/negate and adjust the residual angle.
  - Then STAGES registered micro-rotations using the arctangent table.
  - Datapath width is WIDTH+2 with guard bits.
  - Output is (rotated >>> 1), saturated to signed WIDTH. Net gain ≈ 1.64676/2 ≈ 0.8234, uncorrected; downstream treats this as a fixed scale.
- Latency: STAGES+2 cycles from an accepted input beat to m_valid when en is held high (pre-rotation stage, STAGES stages, output register).
- The last tag and valid travel in sideband registers alongside the data.
- Reset mid-window: flushes the pipeline (m_valid=0 the cycle after reset) and returns to SEARCH. Partial windows are not completed.

Decomposition:
- Package freq_corr_pkg holds: phase_t (signed PHASE_WIDTH), sample_t ({Q,I} struct), the state enum {SEARCH, TRACK}, the CORDIC arctangent constant table atan(2^-i) scaled to phase units, and the constant CORDIC_GAIN_Q15.
- Sub-module cordic_rotate contains the pre-rotation and STAGES pipeline, with an en input and passthrough sideband bits (valid, last).
- The top level holds the FSM, phase accumulator, counter, and output saturation.

Test Plan:
1. 100 beats with s_last=0 -> s_ready=1 throughout, m_valid never asserts, tracking=0.
2. s_user=0, s_last on the first of LENGTH constant samples I=0x4000, Q=0 -> exactly 240 outputs with I=0x34B0±4 and Q=0±4, first output STAGES+2 cycles after input, m_last only on output 240, tracking drops after it.
3. s_user=0x40000000 (π/2/sample), constant I=0x4000 -> outputs cycle (A,0),(0,-A),(-A,0),(0,A) with A≈0x34B0±4, exercising quadrant pre-rotation and accumulator wrap.
4. s_user=0x20000000, m_ready toggled pseudo-randomly at 50% -> output sequence bit-identical to the m_ready=1 run, no drops or duplicates, m_data stable during stalls.
5. Full-scale input I=Q=0x7FFF at angle π/4 -> I saturates to 0x7FFF, no wrap to negative.
6. reset asserted at sample 50 of a window -> m_valid=0 the next cycle, tracking=0; a later s_last starts a fresh 240-sample window with acc=0.

Source files
------------

// File: rtl/frequency_correction_pkg.sv
// Shared types and constants for the frequency correction block.
//   phase_t   : signed phase word, 2^PHASE_WIDTH_DEF spans 2*pi
//   sample_t  : packed {Q,I} sample
//   state_t   : SEARCH / TRACK
//   atan_lut  : CORDIC arctangent table, atan(2^-i) in phase units
package freq_corr_pkg;

  localparam int WIDTH_DEF       = 16;
  localparam int PHASE_WIDTH_DEF = 32;
  localparam int STAGES_DEF      = 16;
  localparam int LENGTH_DEF      = 240;

  // Uncorrected CORDIC gain (1.64676) in Q15. The output halves the rotated
  // value, so the net gain seen downstream is about 0.8234.
  localparam int CORDIC_GAIN_Q15 = 53961;

  typedef logic signed [PHASE_WIDTH_DEF-1:0] phase_t;

  typedef struct packed {
    logic signed [WIDTH_DEF-1:0] q;
    logic signed [WIDTH_DEF-1:0] i;
  } sample_t;

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  // atan(2^-idx) scaled so that 2^32 = 2*pi.
  function automatic phase_t atan_lut(input int idx);
    phase_t v;
    case (idx)
      0:  v = 32'h2000_0000;
      1:  v = 32'h12E4_051E;
      2:  v = 32'h09FB_385B;
      3:  v = 32'h0511_11D4;
      4:  v = 32'h028B_0D43;
      5:  v = 32'h0145_D7E1;
      6:  v = 32'h00A2_F61E;
      7:  v = 32'h0051_7C55;
      8:  v = 32'h0028_BE53;
      9:  v = 32'h0014_5F2F;
      10: v = 32'h000A_2F98;
      11: v = 32'h0005_17CC;
      12: v = 32'h0002_8BE6;
      13: v = 32'h0001_45F3;
      14: v = 32'h0000_A2FA;
      15: v = 32'h0000_517D;
      16: v = 32'h0000_28BE;
      17: v = 32'h0000_145F;
      18: v = 32'h0000_0A30;
      // Beyond here atan(x) ~= x, so each entry halves the previous one.
      default: v = phase_t'(32'h0000_0518) >>> (idx - 19);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/frequency_correction_if.sv
// Valid/ready stream carrying {Q,I} data, a user word and a last flag.
//   master : drives valid, data, user, last; receives ready
//   slave  : receives valid, data, user, last; drives ready
interface frequency_correction_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [USER_W-1:0] user;
  logic              last;

  modport master (output valid, output data, output user, output last, input ready);
  modport slave  (input valid, input data, input user, input last, output ready);
endinterface

// File: rtl/frequency_correction_cordic_rotate.sv
// Pipelined rotation-mode CORDIC: rotates (in_x, in_y) by in_angle.
//   clk, reset          : clock, synchronous active-high reset (sideband only)
//   en                  : pipeline advance enable; everything holds when low
//   in_valid, in_last   : sideband bits carried alongside the sample
//   in_x, in_y, in_angle: sample and rotation angle (2^PHASE_WIDTH = 2*pi)
//   out_valid, out_last : sideband after STAGES+1 registers
//   out_x, out_y        : rotated sample, WIDTH+2 bits, carries CORDIC gain
module cordic_rotate
  import freq_corr_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int STAGES      = STAGES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic signed [WIDTH-1:0]       in_x,
  input  logic signed [WIDTH-1:0]       in_y,
  input  logic signed [PHASE_WIDTH-1:0] in_angle,
  output logic                          out_valid,
  output logic                          out_last,
  output logic signed [WIDTH+1:0]       out_x,
  output logic signed [WIDTH+1:0]       out_y
);

  localparam int DW = WIDTH + 2;
  localparam logic signed [PHASE_WIDTH-1:0] HALF_PI     = {2'b01, {(PHASE_WIDTH-2){1'b0}}};
  localparam logic signed [PHASE_WIDTH-1:0] NEG_HALF_PI = {2'b11, {(PHASE_WIDTH-2){1'b0}}};

  logic signed [DW-1:0]          x_q [STAGES+1];
  logic signed [DW-1:0]          y_q [STAGES+1];
  logic signed [PHASE_WIDTH-1:0] z_q [STAGES+1];
  logic [STAGES:0]               v_q;
  logic [STAGES:0]               l_q;

  logic signed [DW-1:0]          x_ext, y_ext, x_pre, y_pre;
  logic signed [PHASE_WIDTH-1:0] z_pre;

  assign x_ext = {{2{in_x[WIDTH-1]}}, in_x};
  assign y_ext = {{2{in_y[WIDTH-1]}}, in_y};

  // The micro-rotations only converge within about +/-99 degrees, so angles
  // beyond +/-pi/2 get an exact quarter turn first via swap/negate.
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = in_angle;
    if (in_angle > HALF_PI) begin
      x_pre = -y_ext;
      y_pre = x_ext;
      z_pre = in_angle - HALF_PI;
    end else if (in_angle < NEG_HALF_PI) begin
      x_pre = y_ext;
      y_pre = -x_ext;
      z_pre = in_angle + HALF_PI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      l_q <= '0;
    end else if (en) begin
      v_q <= {v_q[STAGES-1:0], in_valid};
      l_q <= {l_q[STAGES-1:0], in_last};
    end
  end

  // Data registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      x_q[0] <= x_pre;
      y_q[0] <= y_pre;
      z_q[0] <= z_pre;
      for (int i = 0; i < STAGES; i++) begin
        if (!z_q[i][PHASE_WIDTH-1]) begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] - atan_lut(i);
        end else begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] + atan_lut(i);
        end
      end
    end
  end

  assign out_valid = v_q[STAGES];
  assign out_last  = l_q[STAGES];
  assign out_x     = x_q[STAGES];
  assign out_y     = y_q[STAGES];

endmodule

// File: rtl/frequency_correction.sv
// Frequency offset correction after packet sync. On the beat carrying s.last
// the offset estimate in s.user is latched; that beat and the following
// LENGTH-1 beats are de-rotated by -n*freq and emitted, the final one with
// m.last. Beats outside a window are accepted and dropped.
//   clk, reset : clock, synchronous active-high reset
//   s          : input stream, data={Q,I}, user=signed freq (phase/sample)
//   m          : output stream, data=corrected {Q,I}, user unused (0)
//   tracking   : high while a window is in progress
//
// state  | meaning
// SEARCH | drop beats, wait for s.last to start a window
// TRACK  | feed beats into the CORDIC with an accumulating angle
module frequency_correction
  import freq_corr_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int STAGES      = STAGES_DEF,
  parameter int LENGTH      = LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  frequency_correction_if.slave  s,
  frequency_correction_if.master m,
  output logic                   tracking
);

  localparam int DW = WIDTH + 2;
  localparam int CW = $clog2(LENGTH + 1);
  localparam logic signed [DW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  state_t                        state, state_nxt;
  logic signed [PHASE_WIDTH-1:0] acc, freq, acc_sum, angle;
  logic [CW-1:0]                 count;
  logic                          en, accept, push, push_last, window_end;
  sample_t                       in_smp;

  logic                          c_valid, c_last;
  logic signed [DW-1:0]          c_x, c_y;

  logic                          m_valid_q, m_last_q;
  sample_t                       m_data_q;

  // One enable for the whole path: input, CORDIC and output stall together.
  assign en         = !m_valid_q || m.ready;
  assign s.ready    = en;
  assign accept     = s.valid && en;
  assign acc_sum    = acc + freq;
  assign window_end = (count == CW'(LENGTH - 1));
  assign in_smp     = s.data;

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (accept && s.last) state_nxt = TRACK;
      TRACK:   if (accept && window_end) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    angle     = '0;
    tracking  = (state == TRACK);
    case (state)
      SEARCH: push = accept && s.last;
      TRACK: begin
        push      = accept;
        push_last = window_end;
        angle     = -acc_sum;
      end
      default: ;
    endcase
  end

  // The s.last beat is sample 0 (angle 0); acc then holds n*freq after
  // sample n, wrapping freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      freq  <= '0;
      count <= '0;
    end else if (accept) begin
      case (state)
        SEARCH: if (s.last) begin
          freq  <= s.user;
          acc   <= '0;
          count <= CW'(1);
        end
        TRACK: begin
          acc   <= acc_sum;
          count <= window_end ? '0 : count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  cordic_rotate #(
    .WIDTH       (WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .STAGES      (STAGES)
  ) u_cordic (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (push),
    .in_last   (push_last),
    .in_x      (in_smp.i),
    .in_y      (in_smp.q),
    .in_angle  (angle),
    .out_valid (c_valid),
    .out_last  (c_last),
    .out_x     (c_x),
    .out_y     (c_y)
  );

  // Halve to bring the CORDIC gain below 1, then clamp; a full-scale input
  // rotated onto an axis would otherwise wrap.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] h;
    h = v >>> 1;
    if (h > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (h < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return h[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (en) begin
      m_valid_q <= c_valid;
      m_last_q  <= c_valid && c_last;
      if (c_valid) begin
        m_data_q.i <= sat(c_x);
        m_data_q.q <= sat(c_y);
      end
    end
  end

  assign m.valid = m_valid_q;
  assign m.last  = m_last_q;
  assign m.data  = m_data_q;
  assign m.user  = '0;

endmodule
